traffic_timer: RTL and testbench
================================

TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 The block SHALL have a parameter CLK_DIV, default 100000000, giving clk cycles per one-second tick (minimum 2).
REQ-002 The block SHALL have parameters BASE_DEFAULT, default 6; EXT_DEFAULT, default 3; YEL_DEFAULT, default 2, giving the power-up interval values in seconds.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port startTimer, input, 1 bit: one-cycle pulse that loads and starts the interval countdown.
REQ-006 Port timeParameter, input, 2 bits: interval select; 00 base, 01 extended, 10 yellow, 11 treated as base.
REQ-007 Port reprogram, input, 1 bit: one-cycle write strobe for the interval registers.
REQ-008 Port progSelect, input, 2 bits: interval register to write; encoding as timeParameter; 11 means no write.
REQ-009 Port progValue, input, 4 bits: new interval in seconds.
REQ-010 Port expired, output, 1 bit: one-cycle pulse when the running interval ends.
REQ-011 Port running, output, 1 bit: high while a countdown is in progress.
REQ-012 Port secondsLeft, output, 4 bits: remaining whole seconds of the current countdown.

Function
REQ-013 Three 4-bit interval registers SHALL hold base, extended and yellow values.
REQ-014 When reprogram=1, the register chosen by progSelect SHALL be written with progValue.
REQ-015 A progValue of 0 SHALL be stored as 1.
REQ-016 A reprogram SHALL not alter a countdown in progress; the new value applies only at the next load.
REQ-017 When startTimer=1, the counter SHALL load the register selected by timeParameter, clear the prescaler, set running=1 and force expired=0.
REQ-018 When reprogram and startTimer occur in the same cycle, the load SHALL use the value held before the write.
REQ-019 The prescaler SHALL count 0..CLK_DIV-1 while running=1; a tick is the cycle in which it equals CLK_DIV-1.
REQ-020 On each tick the counter SHALL decrement by 1.
REQ-021 On the tick that takes the counter from 1 to 0: expired SHALL pulse high for exactly the next cycle, running SHALL drop, and the counter SHALL hold 0.
REQ-022 Expired SHALL therefore assert exactly N*CLK_DIV cycles after the cycle in which startTimer was sampled, where N is the loaded value.
REQ-023 A startTimer arriving while running=1 SHALL restart the countdown; startTimer takes priority over a coincident tick or expiry, and no expired pulse is produced for the aborted interval.
REQ-024 While idle (running=0), the prescaler and counter SHALL hold and expired SHALL remain 0.
REQ-025 secondsLeft SHALL equal the counter value; the counter SHALL never wrap below 0.

Reset
REQ-026 Asserting reset SHALL immediately set expired=0, running=0, secondsLeft=0, prescaler=0.
REQ-027 Asserting reset SHALL load the interval registers with BASE_DEFAULT, EXT_DEFAULT and YEL_DEFAULT.
REQ-028 Reset asserted mid-countdown SHALL abort the countdown with no expired pulse, and SHALL discard any earlier reprogram writes.
REQ-029 After reset deasserts, the block SHALL stay idle until the first startTimer.

Structure
REQ-030 Package traffic_pkg SHALL hold the 2-bit select encodings (BASE_SELECT, EXT_SELECT, YEL_SELECT) and the default interval constants, shared with the light-sequencing FSM.
REQ-031 The prescaler SHALL be a sub-module tick_divider (inputs clk, reset, clear, enable; output tick).
REQ-032 The counter, interval registers and output logic SHALL reside in traffic_timer.

Verification (CLK_DIV=4)
REQ-033 Reset, then startTimer with timeParameter=00 -> expired pulses once, 24 cycles later; secondsLeft steps 6,5,4,3,2,1,0.
REQ-034 reprogram with progSelect=10, progValue=5, then startTimer with timeParameter=10 -> expired after 20 cycles; progValue=0 written to base -> base load expires after 4 cycles.
REQ-035 startTimer with timeParameter=01 (3 s); at cycle 10 reprogram ext=9 -> expiry still at cycle 12; next ext load expires after 36 cycles.
REQ-036 startTimer with timeParameter=00; at cycle 23 a second startTimer with timeParameter=10 -> no expired at cycle 24; expired at cycle 23+8.
REQ-037 startTimer, then reset at cycle 10 -> no expired pulse, running=0, and the registers read back defaults (next base load expires after 24 cycles).
REQ-038 startTimer with timeParameter=11 -> behaves as base (24 cycles); reprogram with progSelect=11 -> no register changes.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared constants for the traffic light timer and the light-sequencing FSM:
//   - 2-bit interval select encodings (used by timeParameter and progSelect)
//   - power-up interval values in seconds
//   - helper that maps a programmed interval of 0 to 1
package traffic_pkg;

    localparam logic [1:0] BASE_SELECT = 2'b00;
    localparam logic [1:0] EXT_SELECT  = 2'b01;
    localparam logic [1:0] YEL_SELECT  = 2'b10;
    localparam logic [1:0] NO_SELECT   = 2'b11;

    localparam int DEF_BASE_S = 6;
    localparam int DEF_EXT_S  = 3;
    localparam int DEF_YEL_S  = 2;

    // A zero interval would expire without ever counting, so it is stored as 1 s.
    function automatic logic [3:0] clamp_interval(input logic [3:0] value);
        return (value == 4'd0) ? 4'd1 : value;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider
// Prescaler producing a one-second tick from clk.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset, counter to 0
//   clear  : synchronous clear, counter to 0 (has priority over enable)
//   enable : count 0..CLK_DIV-1 while high, hold while low
//   tick   : high in the cycle the counter equals CLK_DIV-1 while enabled
module tick_divider #(
    parameter int CLK_DIV = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/traffic_timer.sv
// traffic_timer
// Interval timer for the traffic light sequencer. Holds three programmable
// interval registers (base, extended, yellow) and counts the selected one
// down in whole seconds.
//   clk           : system clock, rising edge
//   reset         : asynchronous active-high reset
//   startTimer    : pulse, loads the selected interval and (re)starts counting
//   timeParameter : interval select for the load (11 selects base)
//   reprogram     : pulse, writes progValue into the register chosen by progSelect
//   progSelect    : register to write (11 = no write)
//   progValue     : new interval in seconds (0 is stored as 1)
//   expired       : one-cycle pulse at the end of a countdown
//   running       : high while counting
//   secondsLeft   : current counter value
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int CLK_DIV      = 100000000,
    parameter int BASE_DEFAULT = DEF_BASE_S,
    parameter int EXT_DEFAULT  = DEF_EXT_S,
    parameter int YEL_DEFAULT  = DEF_YEL_S
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startTimer,
    input  logic [1:0] timeParameter,
    input  logic       reprogram,
    input  logic [1:0] progSelect,
    input  logic [3:0] progValue,
    output logic       expired,
    output logic       running,
    output logic [3:0] secondsLeft
);

    logic [3:0] base_q, base_d;
    logic [3:0] ext_q, ext_d;
    logic [3:0] yel_q, yel_d;
    logic [3:0] count_q, count_d;
    logic       running_q, running_d;
    logic       expired_q, expired_d;
    logic [3:0] load_val;
    logic       tick;

    // startTimer clears the prescaler so a restart always gets a full first second.
    tick_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_divider (
        .clk    (clk),
        .reset  (reset),
        .clear  (startTimer),
        .enable (running_q),
        .tick   (tick)
    );

    // Register file write; the load below reads the _q values, so a write and a
    // start in the same cycle load the old interval.
    always_comb begin
        base_d = base_q;
        ext_d  = ext_q;
        yel_d  = yel_q;
        if (reprogram) begin
            case (progSelect)
                BASE_SELECT: base_d = clamp_interval(progValue);
                EXT_SELECT:  ext_d  = clamp_interval(progValue);
                YEL_SELECT:  yel_d  = clamp_interval(progValue);
                default:     ;
            endcase
        end
    end

    always_comb begin
        case (timeParameter)
            EXT_SELECT: load_val = ext_q;
            YEL_SELECT: load_val = yel_q;
            default:    load_val = base_q;
        endcase
    end

    // Countdown. A start overrides a coincident tick, which is what suppresses
    // the expired pulse of an aborted interval.
    always_comb begin
        count_d   = count_q;
        running_d = running_q;
        expired_d = 1'b0;
        if (startTimer) begin
            count_d   = load_val;
            running_d = 1'b1;
        end else if (running_q && tick) begin
            if (count_q <= 4'd1) begin
                count_d   = 4'd0;
                running_d = 1'b0;
                expired_d = 1'b1;
            end else begin
                count_d = count_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q    <= 4'(BASE_DEFAULT);
            ext_q     <= 4'(EXT_DEFAULT);
            yel_q     <= 4'(YEL_DEFAULT);
            count_q   <= 4'd0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            base_q    <= base_d;
            ext_q     <= ext_d;
            yel_q     <= yel_d;
            count_q   <= count_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign expired     = expired_q;
    assign running     = running_q;
    assign secondsLeft = count_q;

endmodule

// File: tb/tb_traffic_timer.sv
// tb_traffic_timer
// Self-checking bench for traffic_timer with CLK_DIV=4. A behavioural model
// tracks the interval values and, for the active countdown, the load value and
// the number of clock edges since the start; outputs follow from those by
// arithmetic. Table-driven load/expiry scenarios, hand-written corner-case
// sequences, then randomized traffic.
module tb_traffic_timer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       startTimer;
    logic [1:0] timeParameter;
    logic       reprogram;
    logic [1:0] progSelect;
    logic [3:0] progValue;
    logic       expired;
    logic       running;
    logic [3:0] secondsLeft;

    int errors = 0;
    int checks = 0;

    int regs_m[3];
    bit act_m;
    int n_m;
    int k_m;

    typedef struct {
        logic [1:0] ps;
        logic [3:0] pv;
        logic [1:0] tp;
        int         exp_sec;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[7];

    traffic_timer #(
        .CLK_DIV (DIV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .startTimer    (startTimer),
        .timeParameter (timeParameter),
        .reprogram     (reprogram),
        .progSelect    (progSelect),
        .progValue     (progValue),
        .expired       (expired),
        .running       (running),
        .secondsLeft   (secondsLeft)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        regs_m[0] = 6;
        regs_m[1] = 3;
        regs_m[2] = 2;
        act_m = 0;
        n_m = 0;
        k_m = 0;
    endtask

    task automatic check_outputs();
        int e_exp, e_run, e_sec;
        e_exp = 0;
        e_run = 0;
        e_sec = 0;
        if (act_m) begin
            if (k_m < n_m * DIV) begin
                e_run = 1;
                e_sec = n_m - k_m / DIV;
            end else if (k_m == n_m * DIV) begin
                e_exp = 1;
            end
        end
        chk("expired", int'(expired), e_exp);
        chk("running", int'(running), e_run);
        chk("secondsLeft", int'(secondsLeft), e_sec);
    endtask

    task automatic step(input logic st, input logic [1:0] tp, input logic rp,
                        input logic [1:0] ps, input logic [3:0] pv);
        startTimer    = st;
        timeParameter = tp;
        reprogram     = rp;
        progSelect    = ps;
        progValue     = pv;
        @(posedge clk);
        #1;
        if (act_m) k_m++;
        if (st) begin
            n_m   = regs_m[(tp == 2'b11) ? 0 : int'(tp)];
            k_m   = 0;
            act_m = 1;
        end
        if (rp && ps != 2'b11) regs_m[int'(ps)] = (pv == 4'd0) ? 1 : int'(pv);
        startTimer = 1'b0;
        reprogram  = 1'b0;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 1'b0, 2'b00, 4'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs();
    endtask

    task automatic run_until_expired(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            idle();
            if (expired === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int first;

        vecs[0] = '{ps: 2'b11, pv: 4'd7,  tp: 2'b00, exp_sec: 6,  exp_cycles: 24};
        vecs[1] = '{ps: 2'b11, pv: 4'd0,  tp: 2'b11, exp_sec: 6,  exp_cycles: 24};
        vecs[2] = '{ps: 2'b10, pv: 4'd5,  tp: 2'b10, exp_sec: 5,  exp_cycles: 20};
        vecs[3] = '{ps: 2'b01, pv: 4'd15, tp: 2'b01, exp_sec: 15, exp_cycles: 60};
        vecs[4] = '{ps: 2'b00, pv: 4'd0,  tp: 2'b00, exp_sec: 1,  exp_cycles: 4};
        vecs[5] = '{ps: 2'b11, pv: 4'd9,  tp: 2'b01, exp_sec: 15, exp_cycles: 60};
        vecs[6] = '{ps: 2'b10, pv: 4'd1,  tp: 2'b11, exp_sec: 1,  exp_cycles: 4};

        reset = 1'b0;
        startTimer = 1'b0;
        timeParameter = 2'b00;
        reprogram = 1'b0;
        progSelect = 2'b00;
        progValue = 4'd0;
        model_reset();
        #2;
        do_reset();

        // Stays idle after reset until a start arrives.
        for (int i = 0; i < 10; i++) idle();

        // Table: optional write, then load and time the expiry.
        foreach (vecs[v]) begin
            step(1'b0, 2'b00, 1'b1, vecs[v].ps, vecs[v].pv);
            idle();
            step(1'b1, vecs[v].tp, 1'b0, 2'b00, 4'd0);
            chk("load_seconds", int'(secondsLeft), vecs[v].exp_sec);
            run_until_expired(100, cyc);
            chk("expiry_latency", cyc, vecs[v].exp_cycles);
            idle();
            idle();
        end

        // Reprogram mid-countdown does not disturb the running interval.
        do_reset();
        step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 10) step(1'b0, 2'b00, 1'b1, 2'b01, 4'd9);
            else idle();
            if (expired === 1'b1) begin
                cyc = i;
                break;
            end
        end
        chk("ext_mid_reprogram_latency", cyc, 12);
        idle();
        step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
        run_until_expired(100, cyc);
        chk("ext_new_value_latency", cyc, 36);

        // Same-cycle write and start loads the old value.
        step(1'b1, 2'b10, 1'b1, 2'b10, 4'd7);
        run_until_expired(100, cyc);
        chk("write_and_start_old_value", cyc, 8);

        // Restart one cycle before expiry: no pulse for the aborted interval.
        idle();
        do_reset();
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
        first = -1;
        for (int i = 1; i <= 50; i++) begin
            if (i == 23) step(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
            else idle();
            if (i == 24) chk("aborted_no_expire", int'(expired), 0);
            if (expired === 1'b1 && first < 0) first = i;
        end
        chk("restart_expiry_cycle", first, 31);

        // Restart exactly on the expiry tick also suppresses the pulse.
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
        for (int i = 1; i < 24; i++) idle();
        step(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
        chk("restart_on_tick_no_expire", int'(expired), 0);
        run_until_expired(100, cyc);
        chk("restart_on_tick_latency", cyc, 8);

        // Reset mid-countdown after a reprogram: abort and restore defaults.
        step(1'b0, 2'b00, 1'b1, 2'b00, 4'd2);
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
        for (int i = 1; i < 10; i++) idle();
        do_reset();
        chk("reset_running_low", int'(running), 0);
        for (int i = 0; i < 30; i++) idle();
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
        run_until_expired(100, cyc);
        chk("post_reset_base_latency", cyc, 24);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 39) == 0,
                     2'($urandom_range(0, 3)),
                     $urandom_range(0, 9) == 0,
                     2'($urandom_range(0, 3)),
                     4'($urandom_range(0, 15)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
